// File: rtl/arbiter_rr.sv
// Clocked NCH-input arbiter-merge for 4-phase req/ack/data channels.
// All outputs registered; grant held from selection until the cycle returns to IDLE.
module arbiter_rr #(
  parameter int unsigned N   = 32'd8,
  parameter int unsigned NCH = 32'd4,
  parameter bit          RR  = 1'b1,
  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   r_i,
  output logic [NCH-1:0]   a_i,
  input  logic [NCH*N-1:0] d_i,
  output logic             r_o,
  input  logic             a_o,
  output logic [N-1:0]     d_o,
  output logic [IW-1:0]    g_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK,
    REL
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   grant_reg, grant_next;
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic            r_o_reg, r_o_next;
  logic [NCH-1:0]  a_i_reg, a_i_next;
  logic [N-1:0]    d_o_reg, d_o_next;

  logic [N-1:0]    d_ch [NCH];
  logic [NCH-1:0]  grant_oh;
  logic            grant_req;
  logic            any_req;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   ptr_wrap;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign d_ch[gi]     = d_i[gi*N +: N];
      assign grant_oh[gi] = (grant_reg == IW'(gi));
    end
  endgenerate

  assign grant_req = |(r_i & grant_oh);

  // Scan downward so the last hit wins: that is the first requester at or after base.
  always_comb begin
    int unsigned base;
    int unsigned idx;
    any_req = 1'b0;
    pick    = '0;
    base    = RR ? 32'(ptr_reg) : 32'd0;
    idx     = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = (base + 32'(k)) % NCH;
      if (r_i[IW'(idx)]) begin
        any_req = 1'b1;
        pick    = IW'(idx);
      end
    end
  end

  assign ptr_wrap = (grant_reg == IW'(NCH - 1)) ? '0 : grant_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    r_o_next   = r_o_reg;
    a_i_next   = a_i_reg;
    d_o_next   = d_o_reg;
    case (state_reg)
      IDLE: begin
        // A consumer still holding a_o has not returned to zero; no new grant yet.
        if (any_req && !a_o) begin
          grant_next = pick;
          d_o_next   = d_ch[pick];
          r_o_next   = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (a_o) begin
          a_i_next   = grant_oh;
          state_next = ACK;
        end
      end
      ACK: begin
        if (!grant_req) begin
          r_o_next   = 1'b0;
          state_next = REL;
        end
      end
      REL: begin
        if (!a_o) begin
          a_i_next   = '0;
          ptr_next   = ptr_wrap;
          state_next = IDLE;
        end
      end
      default: begin
        r_o_next   = 1'b0;
        a_i_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      ptr_reg   <= '0;
      r_o_reg   <= 1'b0;
      a_i_reg   <= '0;
      d_o_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
      r_o_reg   <= r_o_next;
      a_i_reg   <= a_i_next;
      d_o_reg   <= d_o_next;
    end
  end

  assign r_o = r_o_reg;
  assign a_i = a_i_reg;
  assign d_o = d_o_reg;
  assign g_o = grant_reg;

endmodule

// File: tb/tb_arbiter_rr.sv
// Directed bench for arbiter_rr: reset, single, round-robin, fixed priority,
// stuck consumer and a randomised-delay sequence against a pointer model.
module tb_arbiter_rr;
  localparam int N   = 8;
  localparam int NCH = 4;
  localparam int IW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit               fx = 1'b0;
  logic [NCH-1:0]   r_i_v = '0;
  logic [NCH*N-1:0] d_i_v = '0;
  logic             a_o_v = 1'b0;

  logic [NCH-1:0] r_i_rr, r_i_fx, a_i_rr, a_i_fx, a_i_s;
  logic           a_o_rr, a_o_fx, r_o_rr, r_o_fx, r_o_s;
  logic [N-1:0]   d_o_rr, d_o_fx, d_o_s;
  logic [IW-1:0]  g_o_rr, g_o_fx, g_o_s;

  assign r_i_rr = fx ? '0 : r_i_v;
  assign r_i_fx = fx ? r_i_v : '0;
  assign a_o_rr = fx ? 1'b0 : a_o_v;
  assign a_o_fx = fx ? a_o_v : 1'b0;
  assign a_i_s  = fx ? a_i_fx : a_i_rr;
  assign r_o_s  = fx ? r_o_fx : r_o_rr;
  assign d_o_s  = fx ? d_o_fx : d_o_rr;
  assign g_o_s  = fx ? g_o_fx : g_o_rr;

  arbiter_rr #(.N(N), .NCH(NCH), .RR(1'b1)) dut (
    .clk(clk), .rst(rst), .r_i(r_i_rr), .a_i(a_i_rr), .d_i(d_i_v),
    .r_o(r_o_rr), .a_o(a_o_rr), .d_o(d_o_rr), .g_o(g_o_rr)
  );

  arbiter_rr #(.N(N), .NCH(NCH), .RR(1'b0)) dut_fx (
    .clk(clk), .rst(rst), .r_i(r_i_fx), .a_i(a_i_fx), .d_i(d_i_v),
    .r_o(r_o_fx), .a_o(a_o_fx), .d_o(d_o_fx), .g_o(g_o_fx)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      total++;
      assert ($onehot0(a_i_s)) else begin
        bad++;
        $error("FAIL onehot0 observed=%b expected=at most one bit", a_i_s);
      end
    end
  end

  task automatic do_reset();
    rst   = 1'b1;
    r_i_v = '0;
    a_o_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_data(input int ch, input logic [N-1:0] v);
    logic [1:0] c;
    c = 2'(ch);
    d_i_v[c*N +: N] = v;
  endtask

  // One full 4-phase cycle on both sides; request for channel g must already be up.
  task automatic run_cycle(input int g, input int hold, input int ack_dly, input bit rereq);
    int         n;
    logic [1:0] c;
    logic [N-1:0] exp_d;
    c     = 2'(g);
    exp_d = d_i_v[c*N +: N];
    n = 0;
    while (r_o_s !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("r_o_rise", 32'(r_o_s), 1);
    chk("g_o_grant", 32'(g_o_s), 32'(g));
    chk("d_o_grant", 32'(d_o_s), 32'(exp_d));
    chk("a_i_before_ack", 32'(a_i_s), 0);
    repeat (ack_dly) @(negedge clk);
    chk("d_o_stable_req", 32'(d_o_s), 32'(exp_d));
    a_o_v = 1'b1;
    n = 0;
    while (a_i_s === '0 && n < 20) begin @(negedge clk); n++; end
    chk("a_i_ack", 32'(a_i_s), 32'(1) << g);
    chk("r_o_in_ack", 32'(r_o_s), 1);
    repeat (hold) @(negedge clk);
    r_i_v[c] = 1'b0;
    n = 0;
    while (r_o_s !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("r_o_fall", 32'(r_o_s), 0);
    chk("a_i_in_rel", 32'(a_i_s), 32'(1) << g);
    chk("d_o_stable_rel", 32'(d_o_s), 32'(exp_d));
    repeat (ack_dly) @(negedge clk);
    a_o_v = 1'b0;
    n = 0;
    while (a_i_s !== '0 && n < 20) begin @(negedge clk); n++; end
    chk("a_i_fall", 32'(a_i_s), 0);
    chk("g_o_hold", 32'(g_o_s), 32'(g));
    $display("txn ch=%0d data=%h fixed=%0d", g, exp_d, fx);
    if (rereq) begin
      set_data(g, N'($urandom));
      r_i_v[c] = 1'b1;
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int ptr;
    int e;
    int seq [6];

    // reset state
    do_reset();
    chk("rst_r_o", 32'(r_o_s), 0);
    chk("rst_a_i", 32'(a_i_s), 0);
    chk("rst_d_o", 32'(d_o_s), 0);
    chk("rst_g_o", 32'(g_o_s), 0);

    // reset in the middle of an ACK phase on ch2
    set_data(2, 8'h3C);
    r_i_v = 4'b0100;
    @(negedge clk);
    chk("t1_r_o", 32'(r_o_s), 1);
    a_o_v = 1'b1;
    @(negedge clk);
    chk("t1_a_i", 32'(a_i_s), 32'h4);
    rst = 1'b1;
    @(negedge clk);
    chk("t1_rst_r_o", 32'(r_o_s), 0);
    chk("t1_rst_a_i", 32'(a_i_s), 0);
    chk("t1_rst_d_o", 32'(d_o_s), 0);
    chk("t1_rst_g_o", 32'(g_o_s), 0);
    r_i_v = '0;
    a_o_v = 1'b0;
    rst   = 1'b0;
    set_data(0, 8'h11);
    r_i_v = 4'b0001;
    run_cycle(0, 0, 0, 1'b0);

    // single request, zero-delay peers: 4-clock cycle
    do_reset();
    set_data(1, 8'hA5);
    r_i_v = 4'b0010;
    @(negedge clk);
    chk("t2_r_o", 32'(r_o_s), 1);
    chk("t2_d_o", 32'(d_o_s), 32'h0A5);
    a_o_v = 1'b1;
    @(negedge clk);
    chk("t2_a_i", 32'(a_i_s), 32'h2);
    r_i_v = '0;
    @(negedge clk);
    chk("t2_r_o_fall", 32'(r_o_s), 0);
    a_o_v = 1'b0;
    @(negedge clk);
    chk("t2_a_i_fall", 32'(a_i_s), 0);
    chk("t2_g_o", 32'(g_o_s), 1);

    // round-robin contention
    do_reset();
    for (int k = 0; k < NCH; k++) set_data(k, N'(8'h40 + k));
    r_i_v = 4'b1111;
    seq = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 6; i++) run_cycle(seq[i], 0, 0, 1'b1);

    // fixed priority: ch3 starved by ch0
    fx = 1'b1;
    do_reset();
    set_data(0, 8'h5A);
    set_data(3, 8'hC3);
    r_i_v = 4'b1001;
    for (int i = 0; i < 3; i++) run_cycle(0, 1, 1, 1'b1);
    chk("t4_ch3_pending", 32'(a_i_s[3]), 0);

    // consumer stuck high on entry to IDLE
    fx = 1'b0;
    do_reset();
    a_o_v = 1'b1;
    set_data(2, 8'h77);
    r_i_v = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_stuck_r_o", 32'(r_o_s), 0);
    end
    a_o_v = 1'b0;
    @(negedge clk);
    chk("t5_r_o", 32'(r_o_s), 1);
    chk("t5_g_o", 32'(g_o_s), 2);
    run_cycle(2, 0, 0, 1'b0);

    // random arrivals and delays against a round-robin pointer model
    do_reset();
    ptr = 0;
    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < NCH; k++) begin
        if (!r_i_v[k]) begin
          set_data(k, N'($urandom));
          if ($urandom_range(1, 0) == 1) r_i_v[k] = 1'b1;
        end
      end
      if (r_i_v == '0) r_i_v[$urandom_range(3, 0)] = 1'b1;
      e = 0;
      for (int off = NCH - 1; off >= 0; off--) begin
        if (r_i_v[(ptr + off) % NCH]) e = (ptr + off) % NCH;
      end
      run_cycle(e, $urandom_range(5, 0), $urandom_range(5, 0), 1'b0);
      ptr = (e + 1) % NCH;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
